// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
// Runs one shift-add (multiply) or restoring-divide step per cycle and
// reports progress through busy/done so the hazard unit can stall EX users.
//
// Handshake: a request is taken on a rising edge where start=1, flush=0 and
// busy=0. Mul/div requests raise busy from that edge until the edge that
// writes HI/LO, at which done pulses for exactly one cycle and busy drops.
// MTHI/MTLO complete on the request edge with no busy and no done. flush
// aborts an in-flight operation without touching HI/LO and without done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // FSM state is kept as a named enum so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    // Shared accumulator: multiply keeps {partial product, multiplier};
    // divide keeps {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   d1_orig;   // dividend as presented, for divide-by-zero HI
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_q;

    // Request decode and operand conditioning
    logic               md_req;
    logic               sgn_op;
    logic               neg1;
    logic               neg2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;

    // Iteration and result datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               b_zero;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign md_req = start && !flush && !op[2];

    // Operand magnitudes, one iteration step for each operation, and final sign fix-up.
    always_comb begin
        sgn_op = ~op[0];
        neg1   = sgn_op & data1[WIDTH-1];
        neg2   = sgn_op & data2[WIDTH-1];
        mag1   = neg1 ? (~data1 + 1'b1) : data1;
        mag2   = neg2 ? (~data2 + 1'b1) : data2;

        // Radix-2 shift-add: add multiplicand when multiplier LSB is set, then shift right.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: shift next dividend bit into the remainder, subtract if it fits.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};

        // Product and quotient take the XOR of operand signs; remainder follows the dividend.
        prod   = (sign1 ^ sign2) ? (~acc + 1'b1) : acc;
        quot   = (sign1 ^ sign2) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem    = sign1 ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        b_zero = (opnd == {WIDTH{1'b0}});

        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = d1_orig;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: flush always returns to IDLE, otherwise walk IDLE->CALC->FIX->IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (md_req) state_next = CALC;
            CALC:    if (flush) state_next = IDLE;
                     else if (cnt == {CW{1'b0}}) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and architectural registers: latch on accept, iterate in CALC, commit in FIX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc     <= '0;
            opnd    <= '0;
            d1_orig <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            sign1   <= 1'b0;
            sign2   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                cnt     <= CW'(WIDTH - 1);
                                is_div  <= op[1];
                                sign1   <= neg1;
                                sign2   <= neg2;
                                opnd    <= op[1] ? mag2 : mag1;
                                acc     <= {{WIDTH{1'b0}}, (op[1] ? mag1 : mag2)};
                                d1_orig <= data1;
                            end
                            3'b100:  hi_q <= data1;
                            3'b101:  lo_q <= data1;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (!flush) begin
                        cnt <= cnt - CW'(1);
                        acc <= is_div ? div_next : mul_next;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        dbz_q  <= is_div & b_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a
// plain-arithmetic reference model of MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO.
module tb_muldiv_unit;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] data1 = '0;
    logic [W-1:0] data2 = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .data1       (data1),
        .data2       (data2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;
    logic [2*W:0] exp_q[$];   // {div_by_zero, hi, lo}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: MIPS result rules expressed with 64-bit arithmetic.
    function automatic logic [2*W:0] ref_md(input logic [2:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        logic [2*W:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            3'd0: begin
                p = sa * sb;
                r = {1'b0, 64'(p)};
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                r  = {1'b0, up};
            end
            3'd2: begin
                if (b == 0) r = {1'b1, a, 32'hFFFF_FFFF};
                else r = {1'b0, 32'(sa % sb), 32'(sa / sb)};   // truncation toward zero
            end
            default: begin
                if (b == 0) r = {1'b1, a, 32'hFFFF_FFFF};
                else r = {1'b0, a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic run_md(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [2*W:0] e;
        int           lat;
        int           busy_n;
        exp_q.push_back(ref_md(o, a, b));
        start = 1'b1; op = o; data1 = a; data2 = b;
        @(negedge clk);
        start = 1'b0; data1 = $urandom; data2 = $urandom;
        check({tag, ".done_clr"}, 64'(done), 64'd0);
        lat = 0;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd33);
        check({tag, ".busy_cycles"}, 64'(busy_n), 64'd33);
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        e = exp_q.pop_front();
        m_dbz = e[2*W];
        m_hi  = e[2*W-1:W];
        m_lo  = e[W-1:0];
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(m_dbz));
    endtask

    task automatic mov(input logic [2:0] o, input logic [W-1:0] a, input string tag);
        start = 1'b1; op = o; data1 = a; data2 = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (o == 3'b100) m_hi = a;
        else if (o == 3'b101) m_lo = a;
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(m_dbz));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        int lat;
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases, with literal results as an independent anchor.
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max.hi_lit", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max.lo_lit", 64'(lo), 64'h0000_0001);
        run_md(3'd0, -32'sd7, 32'd3, "mult_neg");
        check("mult_neg.lo_lit", 64'(lo), 64'hFFFF_FFEB);
        run_md(3'd1, 32'd2, 32'd3, "multu_b2b");
        check("multu_b2b.lo_lit", 64'(lo), 64'd6);
        run_md(3'd2, -32'sd7, 32'd2, "div_neg");
        check("div_neg.lo_lit", 64'(lo), 64'hFFFF_FFFD);
        run_md(3'd3, 32'd100, 32'd7, "divu");
        check("divu.hi_lit", 64'(hi), 64'd2);
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf.lo_lit", 64'(lo), 64'h8000_0000);
        run_md(3'd2, -32'sd5, 32'd0, "div_zero_s");
        run_md(3'd3, 32'd5, 32'd0, "divu_zero");
        check("divu_zero.hi_lit", 64'(hi), 64'd5);

        // div_by_zero holds across moves; flush test with ignored start.
        mov(3'b100, 32'h1234, "mthi");
        mov(3'b101, 32'h5678, "mtlo");
        start = 1'b1; op = 3'd3; data1 = 32'd9; data2 = 32'd2;
        @(negedge clk);                       // after E0
        start = 1'b0;
        repeat (2) @(negedge clk);            // after E2
        start = 1'b1; op = 3'b100; data1 = 32'hAAAA;
        @(negedge clk);                       // after E3
        start = 1'b0;
        check("ignored.busy", 64'(busy), 64'd1);
        check("ignored.hi", 64'(hi), 64'(m_hi));
        repeat (6) @(negedge clk);            // after E9
        flush = 1'b1;
        @(negedge clk);                       // after E10
        flush = 1'b0;
        check("flush.busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("flush.no_done", 64'(seen), 64'd0);
        check("flush.hi", 64'(hi), 64'(m_hi));
        check("flush.lo", 64'(lo), 64'(m_lo));

        // Flush while in the result/fix-up cycle.
        start = 1'b1; op = 3'd1; data1 = 32'd11; data2 = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);           // after E32, final cycle before commit
        check("fixflush.busy_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fixflush.done", 64'(done), 64'd0);
        check("fixflush.busy", 64'(busy), 64'd0);
        check("fixflush.lo", 64'(lo), 64'(m_lo));

        // start together with flush in IDLE is dropped.
        start = 1'b1; flush = 1'b1; op = 3'b100; data1 = 32'hBEEF;
        @(negedge clk);
        op = 3'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("startflush.hi", 64'(hi), 64'(m_hi));
        check("startflush.busy", 64'(busy), 64'd0);

        // Randomized mix of operations.
        for (int k = 0; k < 30; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = '1; end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if (ro <= 3'd3) run_md(ro, ra, rb, $sformatf("rand%0d", k));
            else mov(ro, ra, $sformatf("rand%0d", k));
        end

        // Mid-operation reset discards everything.
        run_md(3'd3, 32'd77, 32'd0, "pre_rst");
        mov(3'b100, 32'hDEAD, "pre_rst_mthi");
        start = 1'b1; op = 3'd0; data1 = 32'd5; data2 = 32'd5;
        @(negedge clk);                       // after E0
        start = 1'b0;
        repeat (4) @(negedge clk);            // after E4
        rst = 1'b0;
        @(negedge clk);                       // after E5
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        check("midrst.hi", 64'(hi), 64'd0);
        check("midrst.lo", 64'(lo), 64'd0);
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        lat = 0;
        run_md(3'd0, 32'd5, 32'd5, "post_rst");
        check("post_rst.lo_lit", 64'(lo), 64'd25);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers. It extends the combinational ALU with the MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO operations.
- Sits beside the ALU in EX. It exposes a busy/done handshake so the hazard-detection unit can stall dependent instructions.
- Uses one shift-add or restoring-divide iteration per cycle.

Parameters:
- WIDTH, 32, operand width and the width of each of HI and LO.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled at the rising edge.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- data1  input  WIDTH  multiplicand / dividend / move source.
- data2  input  WIDTH  multiplier / divisor.
- flush  input  1  abort the in-flight operation (pipeline squash).
- busy  output  1  operation in progress; a new start is ignored while high.
- done  output  1  one-cycle pulse when HI/LO are updated by mul/div.
- div_by_zero  output  1  valid with done; high if the divisor was 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset:
  - rst=0 at an edge: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE.
  - Reset has priority over everything, including mid-operation; a partial result is discarded.
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1, flush=0, op mul/div at edge E0: latch operands into CALC.
    - Signed ops latch absolute values plus sign bits.
    - Iteration counter loads WIDTH-1.
    - busy=1 from E0.
  - start=1, op MTHI/MTLO: hi (resp. lo) <= data1 at E0. No busy, no done, the other register is unchanged.
  - op 11x: no effect.
- CALC:
  - One iteration per edge, E1..E_WIDTH; counter decrements.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - At the edge where counter=0, go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply the sign correction and write hi/lo.
  - done=1 for exactly that one cycle; busy=0 in the same cycle; return to IDLE.
  - Latency from the start edge to done is WIDTH+1 cycles (33 for WIDTH=32).
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH product. Signed product is negated if the operand signs differ.
  - Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Signed overflow (MIN / -1): lo=MIN, hi=0, div_by_zero=0.
  - Divide by zero: lo = all ones, hi = data1 as latched (original signed value for DIV), div_by_zero=1 with done.
- Busy and flush:
  - start while busy=1 is ignored and has no side effects, including MTHI/MTLO.
  - flush=1 in CALC or FIX: go to IDLE at that edge; busy=0 next cycle; hi/lo unchanged; no done pulse.
  - flush=1 and start=1 in IDLE at the same edge: flush wins and the start is dropped.
  - A new start is accepted on the cycle after done, or after a flush, while busy=0.
- Register update rules:
  - div_by_zero holds its value until the next done.
  - done is 0 on every cycle except the FIX exit.
  - hi/lo change only at reset, MTHI/MTLO, or a FIX exit.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after the start edge, busy high for those 33 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then start MULTU 2*3 in the done cycle's next edge -> accepted, hi=0, lo=6.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- Flush and ignored start:
  - Preload hi=0x1234 via MTHI, lo=0x5678 via MTLO (both single-cycle, busy stays 0).
  - DIVU 9/2, with start asserted again (MTHI 0xAAAA) at cycle 3 -> ignored.
  - flush at cycle 10 -> no done, busy=0 next cycle, hi=0x1234, lo=0x5678.
- Mid-operation reset: MULT 5*5, rst=0 at cycle 5 -> next cycle hi=lo=0, busy=done=0. After release, MULT 5*5 -> lo=25 after 33 cycles.
